// File: rtl/detector_tom_pkg.sv
// Shared definitions for the tone detector: FSM states, tone indices and the
// one-hot encoder that the buzzer side also uses.
package detector_tom_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        MEDINDO  = 2'd1,
        CONFIRMA = 2'd2,
        TRAVADO  = 2'd3
    } estado_t;

    localparam int NTONS = 4;

    localparam logic [1:0] TOM0 = 2'd0;
    localparam logic [1:0] TOM1 = 2'd1;
    localparam logic [1:0] TOM2 = 2'd2;
    localparam logic [1:0] TOM3 = 2'd3;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Two-flop synchronizer followed by a registered rising-edge pulse; the pulse
// is high for one cycle, two clocks after the input is first sampled high.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic borda
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic borda_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            borda_reg <= 1'b0;
        end else begin
            sync1_reg <= entrada;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            borda_reg <= sync2_reg & ~prev_reg;
        end
    end

    assign borda = borda_reg;

endmodule

// File: rtl/detector_tom.sv
// Tone receiver: measures the rise-to-rise period of pulso and locks onto one
// of four tones. Define DETECTOR_HOLD_EN to keep seletor across a timeout.
module detector_tom
    import detector_tom_pkg::*;
#(
    parameter int CLOCK_FREQ  = 5000,
    parameter int FREQ0       = 1000,
    parameter int FREQ1       = 500,
    parameter int FREQ2       = 250,
    parameter int FREQ3       = 125,
    parameter int MATCH_COUNT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       conta,
    input  logic       pulso,
    output logic [3:0] seletor,
    output logic       valido,
    output logic       erro
);

    localparam int P0      = CLOCK_FREQ / FREQ0;
    localparam int P1      = CLOCK_FREQ / FREQ1;
    localparam int P2      = CLOCK_FREQ / FREQ2;
    localparam int P3      = CLOCK_FREQ / FREQ3;
    localparam int PER [NTONS] = '{P0, P1, P2, P3};
    localparam int TIMEOUT = 2 * P3;
    localparam int CW      = $clog2(TIMEOUT + 1);
    localparam int MW      = $clog2(MATCH_COUNT + 1);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [MW-1:0] MATCH_C   = MW'(MATCH_COUNT);

    estado_t       estado_reg, estado_next;
    logic [1:0]    cand_reg, cand_next;
    logic [MW-1:0] match_reg, match_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    seletor_reg, seletor_next;
    logic          valido_reg, valido_next;
    logic          erro_reg, erro_next;

    logic             borda;
    logic             timeout;
    logic [31:0]      medido;
    logic [NTONS-1:0] hit;
    logic             tom_ok;
    logic [1:0]       tom_idx;
    logic [3:0]       seletor_timeout;

    detector_borda u_borda (
        .clock   (clock),
        .reset   (reset),
        .entrada (pulso),
        .borda   (borda)
    );

    assign medido  = 32'(cnt_reg);
    assign timeout = (cnt_reg == TIMEOUT_C);

    // One acceptance window per tone: P +/- P/4 (integer division).
    generate
        for (genvar gi = 0; gi < NTONS; gi++) begin : g_janela
            localparam int LO = PER[gi] - PER[gi] / 4;
            localparam int HI = PER[gi] + PER[gi] / 4;
            assign hit[gi] = (medido >= 32'(LO)) && (medido <= 32'(HI));
        end
    endgenerate

    assign tom_ok = |hit;

    always_comb begin
        tom_idx = TOM3;
        if (hit[0])
            tom_idx = TOM0;
        else if (hit[1])
            tom_idx = TOM1;
        else if (hit[2])
            tom_idx = TOM2;
    end

`ifdef DETECTOR_HOLD_EN
    assign seletor_timeout = seletor_reg;
`else
    assign seletor_timeout = 4'b0000;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg  <= OCIOSO;
            cand_reg    <= TOM0;
            match_reg   <= '0;
            cnt_reg     <= '0;
            seletor_reg <= 4'b0000;
            valido_reg  <= 1'b0;
            erro_reg    <= 1'b0;
        end else begin
            estado_reg  <= estado_next;
            cand_reg    <= cand_next;
            match_reg   <= match_next;
            cnt_reg     <= cnt_next;
            seletor_reg <= seletor_next;
            valido_reg  <= valido_next;
            erro_reg    <= erro_next;
        end
    end

    always_comb begin
        estado_next  = estado_reg;
        cand_next    = cand_reg;
        match_next   = match_reg;
        cnt_next     = cnt_reg;
        seletor_next = seletor_reg;
        valido_next  = valido_reg;
        erro_next    = 1'b0;

        if (!conta)
            cnt_next = '0;
        else if (borda)
            cnt_next = CW'(1);
        else if (!timeout)
            cnt_next = cnt_reg + 1'b1;

        if (!conta) begin
            estado_next  = OCIOSO;
            cand_next    = TOM0;
            match_next   = '0;
            seletor_next = 4'b0000;
            valido_next  = 1'b0;
        end else if (estado_reg == OCIOSO) begin
            if (borda)
                estado_next = MEDINDO;
        end else if (timeout) begin
            // A saturated counter also covers the first edge after a timeout:
            // that edge only restarts the measurement, never flags an error.
            estado_next  = MEDINDO;
            match_next   = '0;
            valido_next  = 1'b0;
            seletor_next = seletor_timeout;
        end else if (borda) begin
            case (estado_reg)
                MEDINDO: begin
                    if (tom_ok) begin
                        cand_next  = tom_idx;
                        match_next = MW'(1);
                        if (MATCH_COUNT == 1) begin
                            estado_next  = TRAVADO;
                            seletor_next = onehot(tom_idx);
                            valido_next  = 1'b1;
                        end else begin
                            estado_next = CONFIRMA;
                        end
                    end else begin
                        erro_next = 1'b1;
                    end
                end
                CONFIRMA: begin
                    if (tom_ok && tom_idx == cand_reg) begin
                        match_next = match_reg + 1'b1;
                        if (match_reg + 1'b1 == MATCH_C) begin
                            estado_next  = TRAVADO;
                            seletor_next = onehot(cand_reg);
                            valido_next  = 1'b1;
                        end
                    end else if (tom_ok) begin
                        cand_next  = tom_idx;
                        match_next = MW'(1);
                    end else begin
                        erro_next   = 1'b1;
                        match_next  = '0;
                        estado_next = MEDINDO;
                    end
                end
                TRAVADO: begin
                    if (!(tom_ok && tom_idx == cand_reg)) begin
                        erro_next    = ~tom_ok;
                        match_next   = '0;
                        seletor_next = 4'b0000;
                        valido_next  = 1'b0;
                        estado_next  = MEDINDO;
                    end
                end
                default: ;
            endcase
        end
    end

    assign seletor = seletor_reg;
    assign valido  = valido_reg;
    assign erro    = erro_reg;

endmodule
